// File: rtl/dmem_sized_hs.sv
// Byte-addressable 64-bit data memory with sized, sign/zero-extended accesses,
// a single-outstanding valid/ready handshake and a configurable response latency.
module dmem_sized_hs #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [63:0] resp_rdata_o,
  output logic        resp_misaligned_o,
  output logic        resp_fault_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'd8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          reqReady_q;
  logic          respValid_q;
  logic [63:0]   respRdata_q;
  logic          respMis_q;
  logic          respFault_q;
  logic [63:0]   pendRdata_q;
  logic          pendMis_q;
  logic          pendFault_q;

  logic [63:0]   mem [DEPTH];

  logic [AW-1:0] wordIdx;
  logic [2:0]    byteOff;
  logic [2:0]    alignMask;
  logic [7:0]    laneMask;
  logic [7:0]    wmask;
  logic [63:0]   wshift;
  logic [63:0]   shifted;
  logic [63:0]   loadData;
  logic          misaligned;
  logic          fault;
  logic          doStore;

  always_comb begin
    wordIdx = req_addr_i[3 +: AW];
    byteOff = req_addr_i[2:0];
    case (req_size_i)
      2'd0:    begin alignMask = 3'b000; laneMask = 8'h01; end
      2'd1:    begin alignMask = 3'b001; laneMask = 8'h03; end
      2'd2:    begin alignMask = 3'b011; laneMask = 8'h0F; end
      default: begin alignMask = 3'b111; laneMask = 8'hFF; end
    endcase
    misaligned = (byteOff & alignMask) != 3'b000;
    fault      = !misaligned && (req_addr_i >= LIMIT);
    doStore    = (state_q == IDLE) && req_valid_i && req_we_i && !misaligned && !fault;
    wmask      = laneMask << byteOff;
    wshift     = req_wdata_i << {byteOff, 3'b000};
    shifted    = mem[wordIdx] >> {byteOff, 3'b000};
    case (req_size_i)
      2'd0: loadData = req_unsigned_i ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}}, shifted[7:0]};
      2'd1: loadData = req_unsigned_i ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2: loadData = req_unsigned_i ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: loadData = shifted;
    endcase
    if (misaligned || fault || req_we_i) loadData = 64'd0;
  end

  // Storage has no reset so it can map onto a block/distributed RAM.
  always_ff @(posedge clk) begin
    if (doStore) begin
      for (int b = 0; b < 8; b++) begin
        if (wmask[b]) mem[wordIdx][8*b +: 8] <= wshift[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      reqReady_q  <= 1'b1;
      respValid_q <= 1'b0;
      respRdata_q <= 64'd0;
      respMis_q   <= 1'b0;
      respFault_q <= 1'b0;
      pendRdata_q <= 64'd0;
      pendMis_q   <= 1'b0;
      pendFault_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            reqReady_q <= 1'b0;
            // The visible response fields only change when the response is presented.
            if (LATENCY == 1) begin
              state_q     <= RESP;
              respValid_q <= 1'b1;
              respRdata_q <= loadData;
              respMis_q   <= misaligned;
              respFault_q <= fault;
            end else begin
              state_q     <= WAIT;
              cnt_q       <= CW'(LATENCY - 1);
              pendRdata_q <= loadData;
              pendMis_q   <= misaligned;
              pendFault_q <= fault;
            end
          end
        end
        WAIT: begin
          if (cnt_q == CW'(1)) begin
            state_q     <= RESP;
            respValid_q <= 1'b1;
            respRdata_q <= pendRdata_q;
            respMis_q   <= pendMis_q;
            respFault_q <= pendFault_q;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        RESP: begin
          if (resp_ready_i) begin
            state_q     <= IDLE;
            respValid_q <= 1'b0;
            reqReady_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o       = reqReady_q;
  assign resp_valid_o      = respValid_q;
  assign resp_rdata_o      = respRdata_q;
  assign resp_misaligned_o = respMis_q;
  assign resp_fault_o      = respFault_q;

endmodule

// File: tb/tb_dmem_sized_hs.sv
// Scoreboard bench for dmem_sized_hs: one instance with LATENCY=1 and one with
// LATENCY=3, each driven by directed and random requests against a byte-array model.
module tb_dmem_sized_hs;

  localparam int DEPTH = 256;

  typedef struct {
    logic [63:0] rdata;
    logic        mis;
    logic        fault;
    int          acc;
  } exp_t;

  logic clk;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic reportFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=timeout required=event", name);
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int LAT = (g == 0) ? 1 : 3;

    logic        rstN, reqValid, reqReady, reqWe, reqUns;
    logic [1:0]  reqSize;
    logic [63:0] reqAddr, reqWdata;
    logic        respValid, respReady, respMis, respFault;
    logic [63:0] respRdata;
    logic [7:0]  mm [DEPTH*8];
    exp_t        sb [$];
    bit          done = 1'b0;

    dmem_sized_hs #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk              (clk),
      .rst_n            (rstN),
      .req_valid_i      (reqValid),
      .req_ready_o      (reqReady),
      .req_we_i         (reqWe),
      .req_size_i       (reqSize),
      .req_unsigned_i   (reqUns),
      .req_addr_i       (reqAddr),
      .req_wdata_i      (reqWdata),
      .resp_valid_o     (respValid),
      .resp_ready_i     (respReady),
      .resp_rdata_o     (respRdata),
      .resp_misaligned_o(respMis),
      .resp_fault_o     (respFault)
    );

    // Reference: memory is a flat byte array, loads sum bytes little-endian.
    function automatic exp_t model(input logic we, input logic [1:0] size, input logic uns,
                                   input logic [63:0] addr, input logic [63:0] wdata);
      exp_t        e;
      int          n = 1 << size;
      int          base;
      logic [63:0] v = 64'd0;
      e.rdata = 64'd0;
      e.mis   = (addr % 64'(n)) != 64'd0;
      e.fault = !e.mis && (addr >= 64'(DEPTH * 8));
      e.acc   = 0;
      if (!e.mis && !e.fault) begin
        base = int'(addr);
        if (we) begin
          for (int i = 0; i < n; i++) mm[base + i] = wdata[8*i +: 8];
        end else begin
          for (int i = 0; i < n; i++) v = v | (64'(mm[base + i]) << (8 * i));
          if (!uns && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
          e.rdata = v;
        end
      end
      return e;
    endfunction

    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [63:0] addr, input logic [63:0] wdata);
      int   waitCnt = 0;
      exp_t e;
      @(negedge clk);
      reqValid = 1'b1;
      while (!reqReady && waitCnt < 200) begin
        reqWe    = 1'($urandom);
        reqSize  = 2'($urandom);
        reqUns   = 1'($urandom);
        reqAddr  = {$urandom, $urandom};
        reqWdata = {$urandom, $urandom};
        @(negedge clk);
        waitCnt++;
      end
      if (!reqReady) begin
        reportFail("req_ready wait");
        reqValid = 1'b0;
        return;
      end
      reqWe    = we;
      reqSize  = size;
      reqUns   = uns;
      reqAddr  = addr;
      reqWdata = wdata;
      e        = model(we, size, uns, addr, wdata);
      e.acc    = cyc + 1;
      sb.push_back(e);
      @(posedge clk);
      #1;
      reqValid = 1'b0;
      reqWdata = {$urandom, $urandom};
    endtask

    initial begin
      logic [1:0]  sz;
      logic [63:0] a;
      int          waitCnt;
      for (int i = 0; i < DEPTH * 8; i++) mm[i] = 8'h00;
      rstN = 1'b1; reqValid = 1'b0; reqWe = 1'b0; reqSize = 2'd0; reqUns = 1'b0;
      reqAddr = 64'd0; reqWdata = 64'd0;
      @(negedge clk);
      rstN = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("L%0d reset req_ready", LAT), 64'(reqReady), 64'd1);
      checkOutput($sformatf("L%0d reset resp_valid", LAT), 64'(respValid), 64'd0);
      checkOutput($sformatf("L%0d reset rdata", LAT), respRdata, 64'd0);
      checkOutput($sformatf("L%0d reset misaligned", LAT), 64'(respMis), 64'd0);
      checkOutput($sformatf("L%0d reset fault", LAT), 64'(respFault), 64'd0);
      rstN = 1'b1;

      for (int w = 0; w < DEPTH; w++) applyStimulus(1'b1, 2'd3, 1'b0, 64'(w * 8), 64'd0);

      applyStimulus(1'b1, 2'd3, 1'b0, 64'h10, 64'h1122334455667788);
      applyStimulus(1'b0, 2'd3, 1'b0, 64'h10, 64'd0);
      applyStimulus(1'b1, 2'd0, 1'b0, 64'h13, 64'h00000000000000AB);
      applyStimulus(1'b0, 2'd0, 1'b0, 64'h13, 64'd0);
      applyStimulus(1'b0, 2'd0, 1'b1, 64'h13, 64'd0);
      applyStimulus(1'b0, 2'd3, 1'b0, 64'h10, 64'd0);
      applyStimulus(1'b0, 2'd1, 1'b0, 64'h11, 64'd0);
      applyStimulus(1'b1, 2'd2, 1'b0, 64'h22, 64'h00000000DEADBEEF);
      applyStimulus(1'b0, 2'd3, 1'b0, 64'h20, 64'd0);
      applyStimulus(1'b0, 2'd3, 1'b0, 64'h800, 64'd0);
      applyStimulus(1'b1, 2'd3, 1'b0, 64'h7F8, 64'h8899AABBCCDDEEFF);
      applyStimulus(1'b0, 2'd2, 1'b0, 64'h7FC, 64'd0);
      applyStimulus(1'b0, 2'd1, 1'b1, 64'h7FE, 64'd0);
      applyStimulus(1'b0, 2'd3, 1'b0, 64'hFFFFFFFFFFFFFFF8, 64'd0);

      for (int k = 0; k < 150; k++) begin
        sz = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 9))
          0:       a = {$urandom, $urandom};
          1:       a = 64'($urandom_range(0, DEPTH * 8 + 63));
          2:       a = 64'($urandom_range(0, DEPTH * 8 - 1)) & ~64'((1 << sz) - 1);
          default: a = 64'($urandom_range(0, 63)) & ~64'((1 << sz) - 1);
        endcase
        applyStimulus(1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom});
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      // Reset mid-transaction: the response is dropped but the store persists.
      applyStimulus(1'b1, 2'd3, 1'b0, 64'h08, 64'hCAFEF00D12345678);
      rstN = 1'b0;
      void'(sb.pop_back());
      #1;
      checkOutput($sformatf("L%0d midreset resp_valid", LAT), 64'(respValid), 64'd0);
      checkOutput($sformatf("L%0d midreset req_ready", LAT), 64'(reqReady), 64'd1);
      repeat (2) @(negedge clk);
      rstN = 1'b1;
      repeat (LAT + 2) @(negedge clk);
      checkOutput($sformatf("L%0d post-reset resp_valid", LAT), 64'(respValid), 64'd0);
      applyStimulus(1'b0, 2'd3, 1'b0, 64'h08, 64'd0);

      waitCnt = 0;
      while ((sb.size() != 0 || respValid) && waitCnt < 200) begin
        @(negedge clk);
        waitCnt++;
      end
      if (sb.size() != 0 || respValid) reportFail($sformatf("L%0d drain", LAT));
      done = 1'b1;
    end

    // Monitor: pops the expected response when one appears and holds it to the handshake.
    initial begin
      bit   inResp = 1'b0;
      bit   hsPrev = 1'b0;
      exp_t cur;
      cur = '{64'd0, 1'b0, 1'b0, 0};
      respReady = 1'b0;
      forever begin
        @(negedge clk);
        if (!rstN) begin
          inResp = 1'b0;
          hsPrev = 1'b0;
          respReady = 1'b0;
        end else begin
          if (hsPrev) begin
            checkOutput($sformatf("L%0d resp_valid drop", LAT), 64'(respValid), 64'd0);
            checkOutput($sformatf("L%0d req_ready return", LAT), 64'(reqReady), 64'd1);
            hsPrev = 1'b0;
          end
          if (respValid) begin
            if (!inResp) begin
              if (sb.size() == 0) begin
                reportFail($sformatf("L%0d unexpected response", LAT));
                cur = '{64'd0, 1'b0, 1'b0, cyc - LAT + 1};
              end else begin
                cur = sb.pop_front();
              end
              checkOutput($sformatf("L%0d latency", LAT), 64'(cyc - cur.acc), 64'(LAT - 1));
              inResp = 1'b1;
            end
            checkOutput($sformatf("L%0d rdata", LAT), respRdata, cur.rdata);
            checkOutput($sformatf("L%0d misaligned", LAT), 64'(respMis), 64'(cur.mis));
            checkOutput($sformatf("L%0d fault", LAT), 64'(respFault), 64'(cur.fault));
            checkOutput($sformatf("L%0d req_ready busy", LAT), 64'(reqReady), 64'd0);
            respReady = ($urandom_range(0, 2) == 0);
            if (respReady) begin
              inResp = 1'b0;
              hsPrev = 1'b1;
            end
          end else begin
            respReady = 1'($urandom);
          end
        end
      end
    end
  end

  initial begin
    fork
      wait (cfg[0].done && cfg[1].done);
      repeat (60000) @(posedge clk);
    join_any
    if (!(cfg[0].done && cfg[1].done)) reportFail("watchdog");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
